seg7_scan_ctrl: RTL



---
 rtl/seg7_scan_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// Scan controller for an 8-digit common-anode seven-segment display.
// Double-buffers the CPU-written hex value and swaps it in only at frame boundaries.

module seg7_digit_dec (
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    // Active-high gfedcba pattern; the top level inverts for the common-anode pins.
    always_comb begin
        seg_o = 7'h00;
        case (nib_i)
            4'h0: seg_o = 7'h3F;
            4'h1: seg_o = 7'h06;
            4'h2: seg_o = 7'h5B;
            4'h3: seg_o = 7'h4F;
            4'h4: seg_o = 7'h66;
            4'h5: seg_o = 7'h6D;
            4'h6: seg_o = 7'h7D;
            4'h7: seg_o = 7'h07;
            4'h8: seg_o = 7'h7F;
            4'h9: seg_o = 7'h6F;
            4'hA: seg_o = 7'h77;
            4'hB: seg_o = 7'h7C;
            4'hC: seg_o = 7'h39;
            4'hD: seg_o = 7'h5E;
            4'hE: seg_o = 7'h79;
            4'hF: seg_o = 7'h71;
            default: seg_o = 7'h00;
        endcase
    end
endmodule

module seg7_scan_ctrl #(
    parameter int DIV_CYCLES   = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [7:0]  dig_en,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_sel,
    output logic        frame_done,
    output logic        pending
);
    localparam int NUM_DIGITS = 8;
    localparam int CNT_W      = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(DIV_CYCLES - 1);

    logic [CNT_W-1:0] k_q, k_d;
    logic [2:0]       d_q, d_d;
    logic [31:0]      shadow_q, shadow_d;
    logic [31:0]      display_q, display_d;
    logic             pending_q, pending_d;
    logic [7:0]       seg_q, seg_d;
    logic [7:0]       sel_q, sel_d;
    logic             frame_done_q, frame_done_d;
    logic             last_k, commit, blank_next;

    logic [NUM_DIGITS-1:0][6:0] dig_pat;

    // Decode the value that will be on display next cycle, so registered outputs line up.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
        seg7_digit_dec u_dec (
            .nib_i (display_d[4*i +: 4]),
            .seg_o (dig_pat[i])
        );
    end

    always_comb begin
        last_k    = (k_q == LAST_K);
        commit    = last_k && (d_q == 3'd7);
        k_d       = last_k ? '0 : k_q + 1'b1;
        d_d       = last_k ? d_q + 3'd1 : d_q;
        shadow_d  = wr_en ? wr_data : shadow_q;
        display_d = display_q;
        pending_d = pending_q;
        if (commit) begin
            // A write landing on the commit cycle goes straight to the display.
            if (wr_en)
                display_d = wr_data;
            else if (pending_q)
                display_d = shadow_q;
            pending_d = 1'b0;
        end else if (wr_en) begin
            pending_d = 1'b1;
        end
    end

    if (BLANK_CYCLES == 0) begin : g_no_blank
        assign blank_next = 1'b0;
    end else begin : g_blank
        localparam logic [CNT_W-1:0] BLANK_K = CNT_W'(BLANK_CYCLES);
        assign blank_next = (k_d < BLANK_K);
    end

    always_comb begin
        sel_d        = 8'hFF;
        seg_d        = 8'hFF;
        frame_done_d = (k_d == LAST_K) && (d_d == 3'd7);
        if (!blank_next) begin
            seg_d = {~dp_mask[d_d], ~dig_pat[d_d]};
            if (dig_en[d_d])
                sel_d = ~(8'b1 << d_d);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            k_q          <= '0;
            d_q          <= '0;
            shadow_q     <= '0;
            display_q    <= '0;
            pending_q    <= 1'b0;
            seg_q        <= 8'hFF;
            sel_q        <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            k_q          <= k_d;
            d_q          <= d_d;
            shadow_q     <= shadow_d;
            display_q    <= display_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            sel_q        <= sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_seg      = seg_q;
    assign o_sel      = sel_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;
endmodule
